// File: rtl/exception_unit.sv
// Memory-stage exception arbiter: picks one exception by MIPS priority, holds it across
// AXI stalls and issues a single registered commit to CP0 plus a timed pipeline flush.
module exception_unit #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic        is_in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        eret_i,
    input  logic        adel_ld_i,
    input  logic        ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_next;
    logic [2:0]  cnt;

    logic        int_pend;
    logic        det;
    logic [4:0]  det_code;
    logic [31:0] det_bad;
    logic [31:0] det_newpc;

    logic [4:0]  hold_code;
    logic [31:0] hold_pc;
    logic        hold_ds;
    logic [31:0] hold_bad;
    logic [31:0] hold_newpc;

    logic        commit, capture, use_hold;
    logic [4:0]  cmt_code;
    logic [31:0] cmt_pc;
    logic        cmt_ds;
    logic [31:0] cmt_bad;
    logic [31:0] cmt_newpc;

    // Status/Cause fields outside IM/IP, IE and EXL are irrelevant here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    assign int_pend = (|(cause_i[15:8] & status_i[15:8])) & status_i[0] & ~status_i[1];

    always_comb begin
        det       = 1'b0;
        det_code  = 5'h00;
        det_bad   = '0;
        det_newpc = EXC_VECTOR;
        if (inst_valid_i) begin
            det = 1'b1;
            if (int_pend)       det_code = 5'h01;
            else if (adel_if_i) begin
                det_code = 5'h04;
                det_bad  = pc_i;
            end
            else if (ri_i)      det_code = 5'h0a;
            else if (ov_i)      det_code = 5'h0c;
            else if (syscall_i) det_code = 5'h08;
            else if (break_i)   det_code = 5'h09;
            else if (eret_i) begin
                det_code  = 5'h0e;
                det_newpc = epc_i;
            end
            else if (adel_ld_i) begin
                det_code = 5'h04;
                det_bad  = mem_addr_i;
            end
            else if (ades_i) begin
                det_code = 5'h05;
                det_bad  = mem_addr_i;
            end
            else det = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        capture    = 1'b0;
        use_hold   = 1'b0;
        case (state)
            IDLE: begin
                if (det) begin
                    if (stall_i) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end else begin
                        commit     = 1'b1;
                        state_next = FLUSH;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    commit     = 1'b1;
                    use_hold   = 1'b1;
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cmt_code  = use_hold ? hold_code  : det_code;
    assign cmt_pc    = use_hold ? hold_pc    : pc_i;
    assign cmt_ds    = use_hold ? hold_ds    : is_in_delayslot_i;
    assign cmt_bad   = use_hold ? hold_bad   : det_bad;
    assign cmt_newpc = use_hold ? hold_newpc : det_newpc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            excepttype_o        <= '0;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            bad_addr_o          <= '0;
            flush_o             <= 1'b0;
            newpc_o             <= '0;
            cnt                 <= '0;
        end else if (commit) begin
            excepttype_o        <= {27'd0, cmt_code};
            current_inst_addr_o <= cmt_pc;
            is_in_delayslot_o   <= cmt_ds;
            bad_addr_o          <= cmt_bad;
            flush_o             <= 1'b1;
            newpc_o             <= cmt_newpc;
            cnt                 <= CNT_INIT;
        end else if (state == FLUSH) begin
            excepttype_o <= '0;
            if (cnt == 3'd0) begin
                flush_o <= 1'b0;
                newpc_o <= '0;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // EPC is sampled at detection so a stalled ERET returns to the value seen then.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_code  <= '0;
            hold_pc    <= '0;
            hold_ds    <= 1'b0;
            hold_bad   <= '0;
            hold_newpc <= '0;
        end else if (capture) begin
            hold_code  <= det_code;
            hold_pc    <= pc_i;
            hold_ds    <= is_in_delayslot_i;
            hold_bad   <= det_bad;
            hold_newpc <= det_newpc;
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_exception_unit.sv
// Directed self-checking bench for exception_unit: one default instance and one with a
// three-cycle flush, both driven by the same stimulus.
module tb_exception_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, inst_valid_i, is_in_delayslot_i;
    logic        adel_if_i, ri_i, ov_i, syscall_i, break_i, eret_i, adel_ld_i, ades_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i;

    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
    logic        is_in_delayslot_o, flush_o, busy_o;
    logic [31:0] excepttype3, current_inst_addr3, bad_addr3, newpc3;
    logic        is_in_delayslot3, flush3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .adel_if_i(adel_if_i),
        .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i), .break_i(break_i),
        .eret_i(eret_i), .adel_ld_i(adel_ld_i), .ades_i(ades_i),
        .mem_addr_i(mem_addr_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
        .flush_o(flush_o), .newpc_o(newpc_o), .busy_o(busy_o)
    );

    exception_unit #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .inst_valid_i(inst_valid_i),
        .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i), .adel_if_i(adel_if_i),
        .ri_i(ri_i), .ov_i(ov_i), .syscall_i(syscall_i), .break_i(break_i),
        .eret_i(eret_i), .adel_ld_i(adel_ld_i), .ades_i(ades_i),
        .mem_addr_i(mem_addr_i), .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
        .excepttype_o(excepttype3), .current_inst_addr_o(current_inst_addr3),
        .is_in_delayslot_o(is_in_delayslot3), .bad_addr_o(bad_addr3),
        .flush_o(flush3), .newpc_o(newpc3), .busy_o(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_flags();
        inst_valid_i = 0; is_in_delayslot_i = 0; adel_if_i = 0; ri_i = 0; ov_i = 0;
        syscall_i = 0; break_i = 0; eret_i = 0; adel_ld_i = 0; ades_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0; stall_i = 0; pc_i = '0; mem_addr_i = '0;
        status_i = '0; cause_i = '0; epc_i = '0;
        clear_flags();
        step();
        check("rst_excepttype", excepttype_o, 32'h0);
        check("rst_flush", {31'd0, flush_o}, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'h0);
        check("rst_newpc", newpc_o, 32'h0);
        check("rst_badaddr", bad_addr_o, 32'h0);
        rst = 1;
        step();

        // overflow, no stall
        inst_valid_i = 1; ov_i = 1; pc_i = 32'hBFC00100;
        step();
        check("ov_code", excepttype_o, 32'hc);
        check("ov_pc", current_inst_addr_o, 32'hBFC00100);
        check("ov_flush", {31'd0, flush_o}, 32'h1);
        check("ov_newpc", newpc_o, 32'hBFC00380);
        check("ov_busy", {31'd0, busy_o}, 32'h1);
        clear_flags();
        step();
        check("ov_code_clear", excepttype_o, 32'h0);
        check("ov_flush_clear", {31'd0, flush_o}, 32'h0);
        check("ov_pc_held", current_inst_addr_o, 32'hBFC00100);

        // syscall outranks misaligned load
        inst_valid_i = 1; adel_ld_i = 1; syscall_i = 1; mem_addr_i = 32'h80000003;
        step();
        check("sys_code", excepttype_o, 32'h8);
        check("sys_bad", bad_addr_o, 32'h0);
        syscall_i = 0;
        step();
        check("flush_ignores_flags", excepttype_o, 32'h0);
        step();
        check("adel_ld_code", excepttype_o, 32'h4);
        check("adel_ld_bad", bad_addr_o, 32'h80000003);
        clear_flags();
        step();

        // instruction-fetch misalign outranks ri, BadVAddr = PC
        inst_valid_i = 1; adel_if_i = 1; ri_i = 1; pc_i = 32'hBFC00102;
        step();
        check("adel_if_code", excepttype_o, 32'h4);
        check("adel_if_bad", bad_addr_o, 32'hBFC00102);
        clear_flags();
        step();

        // stalled ERET: EPC captured at detection, later flags ignored
        inst_valid_i = 1; eret_i = 1; epc_i = 32'hBFC00200; stall_i = 1; pc_i = 32'hBFC00300;
        step();
        check("hold_busy", {31'd0, busy_o}, 32'h1);
        eret_i = 0; ov_i = 1; epc_i = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            check("hold_no_commit", excepttype_o, 32'h0);
            check("hold_no_flush", {31'd0, flush_o}, 32'h0);
            step();
        end
        stall_i = 0;
        step();
        check("eret_code", excepttype_o, 32'he);
        check("eret_newpc", newpc_o, 32'hBFC00200);
        check("eret_pc", current_inst_addr_o, 32'hBFC00300);
        check("eret_flush", {31'd0, flush_o}, 32'h1);
        clear_flags();
        step();
        check("eret_done", {31'd0, busy_o}, 32'h0);

        // interrupt in delay slot
        status_i = 32'h0000FF01; cause_i = 32'h00000400;
        inst_valid_i = 1; is_in_delayslot_i = 1; pc_i = 32'hBFC00400;
        step();
        check("int_code", excepttype_o, 32'h1);
        check("int_ds", {31'd0, is_in_delayslot_o}, 32'h1);
        check("int_bad", bad_addr_o, 32'h0);
        clear_flags();
        step();
        status_i = 32'h0000FF03; inst_valid_i = 1;
        step();
        check("int_exl_masked", {31'd0, busy_o}, 32'h0);
        check("int_exl_code", excepttype_o, 32'h0);
        status_i = 32'h0000FF01; inst_valid_i = 0;
        step();
        check("int_invalid_slot", {31'd0, busy_o}, 32'h0);
        status_i = '0; cause_i = '0;

        // three-cycle flush with ri held continuously
        rst = 0; #1; rst = 1;
        inst_valid_i = 1; ri_i = 1;
        step();
        check("ri3_code", excepttype3, 32'ha);
        check("ri3_flush1", {31'd0, flush3}, 32'h1);
        step();
        check("ri3_code_clear", excepttype3, 32'h0);
        check("ri3_flush2", {31'd0, flush3}, 32'h1);
        step();
        check("ri3_flush3", {31'd0, flush3}, 32'h1);
        check("ri3_newpc", newpc3, 32'hBFC00380);
        step();
        check("ri3_flush_end", {31'd0, flush3}, 32'h0);
        check("ri3_idle", {31'd0, busy3}, 32'h0);
        step();
        check("ri3_recommit", excepttype3, 32'ha);
        check("ri3_reflush", {31'd0, flush3}, 32'h1);

        // asynchronous reset mid-flush
        #2 rst = 0;
        #1;
        check("arst_flush", {31'd0, flush3}, 32'h0);
        check("arst_busy", {31'd0, busy3}, 32'h0);
        check("arst_code", excepttype3, 32'h0);
        clear_flags();
        rst = 1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
